// File: rtl/uart_core_if.sv
// Handshake bundle between uart_core and its client: a TX word stream in, and an RX word stream
// out with per-word error flags.
interface uart_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_core.sv
// Parametrised UART transceiver: TX bit-timed from pclk, RX 16x oversampled, one-entry RX hold
// register that reports parity, framing and overrun errors.
module uart_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic      pclk,
  input  logic      rst_n,
  uart_core_if.slave bus,
  output logic      tx,
  input  logic      rx
);
  localparam int DIV_RAW  = CLK_FREQ / (BAUD * 16);
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int BIT_CYC  = 16 * DIV;
  localparam int STOP_CYC = STOP_BITS * BIT_CYC;
  localparam int CNT_W    = $clog2(STOP_CYC + 1);
  localparam int DIV_W    = $clog2(DIV + 1);
  localparam bit ODD      = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // 16x oversample tick, RX only
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

  // ---------------- transmitter ----------------
  state_t               tx_st, tx_st_nx;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_nx;
  logic [2:0]           tx_idx, tx_idx_nx;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nx;
  logic                 tx_par, tx_par_nx;
  logic                 tx_nx, bit_end, stop_end;

  assign bit_end     = (tx_cnt == CNT_W'(BIT_CYC - 1));
  assign stop_end    = (tx_cnt == CNT_W'(STOP_CYC - 1));
  assign bus.tx_ready = (tx_st == S_IDLE);

  always_comb begin
    tx_st_nx  = tx_st;
    tx_cnt_nx = tx_cnt + CNT_W'(1);
    tx_idx_nx = tx_idx;
    tx_sh_nx  = tx_sh;
    tx_par_nx = tx_par;
    unique case (tx_st)
      S_IDLE: begin
        tx_cnt_nx = '0;
        if (bus.tx_valid) begin
          tx_st_nx  = S_START;
          tx_sh_nx  = bus.tx_data;
          tx_par_nx = (^bus.tx_data) ^ ODD;
        end
      end
      S_START: if (bit_end) begin
        tx_st_nx  = S_DATA;
        tx_cnt_nx = '0;
        tx_idx_nx = '0;
      end
      S_DATA: if (bit_end) begin
        tx_cnt_nx = '0;
        tx_sh_nx  = tx_sh >> 1;
        if (tx_idx == 3'(DATA_BITS - 1)) tx_st_nx = (PARITY != 0) ? S_PARITY : S_STOP;
        else                             tx_idx_nx = tx_idx + 3'd1;
      end
      S_PARITY: if (bit_end) begin
        tx_st_nx  = S_STOP;
        tx_cnt_nx = '0;
      end
      S_STOP: if (stop_end) begin
        tx_st_nx  = S_IDLE;
        tx_cnt_nx = '0;
      end
      default: tx_st_nx = S_IDLE;
    endcase
    // Line level is decoded from next state so the pin itself is a flop.
    unique case (tx_st_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = tx_sh_nx[0];
      S_PARITY: tx_nx = tx_par_nx;
      default:  tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
      tx     <= 1'b1;
    end else begin
      tx_st  <= tx_st_nx;
      tx_cnt <= tx_cnt_nx;
      tx_idx <= tx_idx_nx;
      tx_sh  <= tx_sh_nx;
      tx_par <= tx_par_nx;
      tx     <= tx_nx;
    end

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_s, rx_prev;
  assign rx_s = rx_sync[1];

  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
    end

  state_t               rx_st, rx_st_nx;
  logic [3:0]           rx_tc, rx_tc_nx;
  logic [2:0]           rx_idx, rx_idx_nx;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_nx;
  logic                 rx_perr, rx_perr_nx;
  logic                 samp, done;

  // Start is re-checked half a bit in; every later sample is one full bit apart.
  assign samp = tick && (rx_tc == ((rx_st == S_START) ? 4'd7 : 4'd15));

  always_comb begin
    rx_st_nx   = rx_st;
    rx_tc_nx   = tick ? rx_tc + 4'd1 : rx_tc;
    rx_idx_nx  = rx_idx;
    rx_sh_nx   = rx_sh;
    rx_perr_nx = rx_perr;
    done       = 1'b0;
    if (samp) rx_tc_nx = '0;
    unique case (rx_st)
      S_IDLE: begin
        rx_tc_nx = '0;
        if (rx_prev && !rx_s) begin
          rx_st_nx   = S_START;
          rx_perr_nx = 1'b0;
        end
      end
      S_START: if (samp) begin
        rx_st_nx  = rx_s ? S_IDLE : S_DATA;
        rx_idx_nx = '0;
      end
      S_DATA: if (samp) begin
        rx_sh_nx = {rx_s, rx_sh[DATA_BITS-1:1]};
        if (rx_idx == 3'(DATA_BITS - 1)) rx_st_nx = (PARITY != 0) ? S_PARITY : S_STOP;
        else                             rx_idx_nx = rx_idx + 3'd1;
      end
      S_PARITY: if (samp) begin
        rx_perr_nx = rx_s ^ (^rx_sh) ^ ODD;
        rx_st_nx   = S_STOP;
      end
      S_STOP: if (samp) begin
        done     = 1'b1;
        rx_st_nx = S_IDLE;
      end
      default: rx_st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      rx_st   <= S_IDLE;
      rx_tc   <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_perr <= 1'b0;
    end else begin
      rx_st   <= rx_st_nx;
      rx_tc   <= rx_tc_nx;
      rx_idx  <= rx_idx_nx;
      rx_sh   <= rx_sh_nx;
      rx_perr <= rx_perr_nx;
    end

  // Hold register; a frame landing on the handshake cycle replaces the consumed word cleanly.
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_vld, hold_perr, hold_ferr, hold_ovr;

  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      hold_data <= '0;
      hold_vld  <= 1'b0;
      hold_perr <= 1'b0;
      hold_ferr <= 1'b0;
      hold_ovr  <= 1'b0;
    end else if (done) begin
      if (!hold_vld || bus.rx_ready) begin
        hold_data <= rx_sh;
        hold_perr <= rx_perr;
        hold_ferr <= !rx_s;
        hold_ovr  <= 1'b0;
        hold_vld  <= 1'b1;
      end else begin
        hold_ovr  <= 1'b1;
      end
    end else if (hold_vld && bus.rx_ready) begin
      hold_vld  <= 1'b0;
      hold_perr <= 1'b0;
      hold_ferr <= 1'b0;
      hold_ovr  <= 1'b0;
    end

  assign bus.rx_data       = hold_data;
  assign bus.rx_valid      = hold_vld;
  assign bus.rx_parity_err = hold_perr;
  assign bus.rx_frame_err  = hold_ferr;
  assign bus.rx_overrun    = hold_ovr;
endmodule
